// File: rtl/dds_pkg.sv
// ---------------------------------------------------------------------------
// dds_pkg
// Shared definitions for the dds_wavegen direct digital synthesiser.
//   - Default widths for the output samples, phase path and sine table.
//   - sin_mag(): constant function that builds the quarter-wave sine
//     magnitude table at elaboration time.
// Contains no ports and no logic.
// ---------------------------------------------------------------------------
package dds_pkg;

   localparam int DEF_OUTPUT_WIDTH   = 12;
   localparam int DEF_PHASE_WIDTH    = 32;
   localparam int DEF_LUT_ADDR_WIDTH = 10;

   // Widest magnitude sin_mag() can return. Callers size-cast the result.
   localparam int MAG_MAX_W = 16;

   // pi/2 in Q2.30 fixed point.
   localparam longint HALF_PI_Q30 = 64'sd1686629713;

   // Quarter-wave magnitude for table entry k:
   //   round((2^(out_w-1)-1) * sin(pi/2 * (k+0.5) / 2^addr_w))
   // The angle is sampled at the bin centre, so the table is symmetric
   // under the ~index mirroring. The sine is a Taylor series in Q30
   // integer arithmetic, truncated at the x^15 term, which is far below
   // one output LSB over [0, pi/2].
   function automatic logic [MAG_MAX_W-1:0] sin_mag(input int k,
                                                    input int addr_w,
                                                    input int out_w);
      longint x;
      longint x2;
      longint term;
      longint sum;
      longint amp;
      longint r;
      x    = (HALF_PI_Q30 * longint'(2 * k + 1)) >>> (addr_w + 1);
      x2   = (x * x) >>> 30;
      term = x;
      sum  = x;
      for (int n = 1; n <= 7; n++) begin
         term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
         sum  = sum + term;
      end
      amp = (longint'(1) <<< (out_w - 1)) - 1;
      r   = (amp * sum + (longint'(1) <<< 29)) >>> 30;
      return r[MAG_MAX_W-1:0];
   endfunction

endpackage

// File: rtl/dds_sin_rom.sv
// ---------------------------------------------------------------------------
// dds_sin_rom
// Quarter-wave sine ROM with quadrant mirroring and offset-binary sign
// logic. The output is registered and forms the last pipeline stage of the
// sine path.
// Ports:
//   clock     in   sample clock, rising edge
//   reset     in   asynchronous active-low reset, clears wave_sin to 0
//   phase     in   top LUT_ADDR_WIDTH+2 bits of the offset phase
//                  ([A+1:A] = quadrant, [A-1:0] = table index)
//   wave_sin  out  unsigned offset-binary sine sample
// ---------------------------------------------------------------------------
module dds_sin_rom
   import dds_pkg::*;
#(
   parameter int OUTPUT_WIDTH   = DEF_OUTPUT_WIDTH,
   parameter int LUT_ADDR_WIDTH = DEF_LUT_ADDR_WIDTH
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [LUT_ADDR_WIDTH+1:0] phase,
   output logic [OUTPUT_WIDTH-1:0]   wave_sin
);

   localparam int MAG_W     = OUTPUT_WIDTH - 1;
   localparam int LUT_DEPTH = 1 << LUT_ADDR_WIDTH;

   logic [MAG_W-1:0] rom [0:LUT_DEPTH-1];

   // Each entry is an elaboration-time constant, so the table reduces to
   // pure combinational decode.
   for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_rom
      localparam logic [MAG_W-1:0] ENTRY =
         MAG_W'(sin_mag(k, LUT_ADDR_WIDTH, OUTPUT_WIDTH));
      assign rom[k] = ENTRY;
   end

   logic [1:0]                quadrant;
   logic [LUT_ADDR_WIDTH-1:0] index;
   logic [LUT_ADDR_WIDTH-1:0] addr;
   logic [MAG_W-1:0]          mag;
   logic [OUTPUT_WIDTH-1:0]   midscale;
   logic [OUTPUT_WIDTH-1:0]   sample;

   assign quadrant = phase[LUT_ADDR_WIDTH+1:LUT_ADDR_WIDTH];
   assign index    = phase[LUT_ADDR_WIDTH-1:0];

   // Quadrants 1 and 3 run the quarter wave backwards.
   assign addr = quadrant[0] ? ~index : index;
   assign mag  = rom[addr];

   assign midscale = {1'b1, {MAG_W{1'b0}}};

   // Upper half-cycle adds the magnitude, lower half subtracts it. The
   // magnitude peaks at midscale-1, so neither direction can wrap.
   assign sample = quadrant[1] ? (midscale - {1'b0, mag})
                               : (midscale + {1'b0, mag});

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wave_sin <= '0;
      end else begin
         wave_sin <= sample;
      end
   end

endmodule

// File: rtl/dds_wavegen.sv
// ---------------------------------------------------------------------------
// dds_wavegen
// Direct digital synthesiser producing four phase-aligned waveforms from a
// single phase accumulator.
//   stage 1: acc     <= acc + fre_word          (mod 2^PHASE_WIDTH)
//   stage 2: phase_r <= acc + pha_word          (mod 2^PHASE_WIDTH)
//   stage 3: all four outputs registered from phase_r
// There is no valid/ready handshake: a new sample is produced every clock,
// and fre_word / pha_word are sampled on every rising edge.
// Ports:
//   clock     in   sample clock (equals the DAC sample rate)
//   reset     in   asynchronous active-low reset
//   fre_word  in   phase increment per clock
//   pha_word  in   phase offset, 2^PHASE_WIDTH = 360 degrees
//   wave_sin  out  sine sample, offset binary
//   wave_tri  out  triangle sample
//   wave_saw  out  rising sawtooth sample
//   wave_sqr  out  square sample, all ones or all zeros
// ---------------------------------------------------------------------------
module dds_wavegen
   import dds_pkg::*;
#(
   parameter int OUTPUT_WIDTH   = DEF_OUTPUT_WIDTH,
   parameter int PHASE_WIDTH    = DEF_PHASE_WIDTH,
   parameter int LUT_ADDR_WIDTH = DEF_LUT_ADDR_WIDTH
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [PHASE_WIDTH-1:0]  fre_word,
   input  logic [PHASE_WIDTH-1:0]  pha_word,
   output logic [OUTPUT_WIDTH-1:0] wave_sin,
   output logic [OUTPUT_WIDTH-1:0] wave_tri,
   output logic [OUTPUT_WIDTH-1:0] wave_saw,
   output logic [OUTPUT_WIDTH-1:0] wave_sqr
);

   logic [PHASE_WIDTH-1:0] acc;
   logic [PHASE_WIDTH-1:0] phase_r;

   // Stages 1 and 2. Both sums wrap silently; the wrap is what makes the
   // phase periodic.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc     <= '0;
         phase_r <= '0;
      end else begin
         acc     <= acc + fre_word;
         phase_r <= acc + pha_word;
      end
   end

   // Top OUTPUT_WIDTH phase bits drive saw/tri/sqr.
   logic [OUTPUT_WIDTH-1:0] p;
   logic [OUTPUT_WIDTH-1:0] tri_up;
   logic [OUTPUT_WIDTH-1:0] tri_next;

   assign p        = phase_r[PHASE_WIDTH-1 -: OUTPUT_WIDTH];
   assign tri_up   = {p[OUTPUT_WIDTH-2:0], 1'b0};
   // Second half of the cycle folds the doubled ramp back down.
   assign tri_next = p[OUTPUT_WIDTH-1] ? ~tri_up : tri_up;

   // Fractional phase bits below the output resolution are intentionally
   // not used by any waveform.
   logic unused_phase;
   assign unused_phase = ^phase_r;

   // Stage 3 for saw/tri/sqr, in parallel with the registered sine ROM so
   // all four outputs change on the same edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wave_tri <= '0;
         wave_saw <= '0;
         wave_sqr <= '0;
      end else begin
         wave_saw <= p;
         wave_tri <= tri_next;
         wave_sqr <= {OUTPUT_WIDTH{~phase_r[PHASE_WIDTH-1]}};
      end
   end

   dds_sin_rom #(
      .OUTPUT_WIDTH   (OUTPUT_WIDTH),
      .LUT_ADDR_WIDTH (LUT_ADDR_WIDTH)
   ) u_sin_rom (
      .clock    (clock),
      .reset    (reset),
      .phase    (phase_r[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH+2]),
      .wave_sin (wave_sin)
   );

endmodule

// File: tb/tb_dds_wavegen.sv
// ---------------------------------------------------------------------------
// tb_dds_wavegen
// Directed self-checking bench for dds_wavegen. Outputs are sampled 1 time
// unit after each rising edge; inputs are changed at the same point.
// ---------------------------------------------------------------------------
module tb_dds_wavegen;

   localparam int OW = 12;
   localparam int PW = 32;

   logic          clock;
   logic          reset;
   logic [PW-1:0] fre_word;
   logic [PW-1:0] pha_word;
   logic [OW-1:0] wave_sin;
   logic [OW-1:0] wave_tri;
   logic [OW-1:0] wave_saw;
   logic [OW-1:0] wave_sqr;

   int checks   = 0;
   int failures = 0;

   logic [4*OW-1:0] exp_q[$];

   dds_wavegen #(
      .OUTPUT_WIDTH   (OW),
      .PHASE_WIDTH    (PW),
      .LUT_ADDR_WIDTH (10)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .fre_word (fre_word),
      .pha_word (pha_word),
      .wave_sin (wave_sin),
      .wave_tri (wave_tri),
      .wave_saw (wave_saw),
      .wave_sqr (wave_sqr)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Hold reset across two edges with the given words, release 1 unit
   // after an edge. After release edge n (n >= 2) outputs show
   // acc = (n-2)*fre, offset by pha.
   task automatic apply_reset(input logic [PW-1:0] f, input logic [PW-1:0] ph);
      reset    = 1'b0;
      fre_word = f;
      pha_word = ph;
      tick();
      tick();
      reset = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset    = 1'b0;
      fre_word = 32'h1234_5678;
      pha_word = 32'h9abc_def0;
      #2;
      checks++;
      if ({wave_sin, wave_tri, wave_saw, wave_sqr} !== '0) begin
         failures++;
         $display("FAIL reset_async_t0 got sin=%0d tri=%0d saw=%0d sqr=%0d want all 0",
                  wave_sin, wave_tri, wave_saw, wave_sqr);
      end
      for (int i = 0; i < 4; i++) begin
         fre_word = $urandom();
         pha_word = $urandom();
         tick();
         checks++;
         if ({wave_sin, wave_tri, wave_saw, wave_sqr, dut.acc} !== '0) begin
            failures++;
            $display("FAIL reset_hold[%0d] got sin=%0d tri=%0d saw=%0d sqr=%0d acc=%h want all 0",
                     i, wave_sin, wave_tri, wave_saw, wave_sqr, dut.acc);
         end
      end
      fre_word = '0;
      pha_word = '0;
      reset    = 1'b1;
      tick();
      tick();
      checks++;
      if (wave_sin !== 12'd2050 || wave_tri !== 12'd0 ||
          wave_saw !== 12'd0 || wave_sqr !== 12'd4095) begin
         failures++;
         $display("FAIL reset_release got sin=%0d tri=%0d saw=%0d sqr=%0d want 2050 0 0 4095",
                  wave_sin, wave_tri, wave_saw, wave_sqr);
      end
   endtask

   task automatic test_quarter_step();
      int e_saw [4] = '{0, 1024, 2048, 3072};
      int e_tri [4] = '{0, 2048, 4095, 2047};
      int e_sin [4] = '{2050, 4095, 2046, 1};
      int e_sqr [4] = '{4095, 4095, 0, 0};
      apply_reset(32'h4000_0000, 32'h0);
      tick();
      tick();
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (wave_saw !== OW'(e_saw[i%4]) || wave_tri !== OW'(e_tri[i%4]) ||
             wave_sin !== OW'(e_sin[i%4]) || wave_sqr !== OW'(e_sqr[i%4])) begin
            failures++;
            $display("FAIL quarter_step[%0d] got sin=%0d tri=%0d saw=%0d sqr=%0d want %0d %0d %0d %0d",
                     i, wave_sin, wave_tri, wave_saw, wave_sqr,
                     e_sin[i%4], e_tri[i%4], e_saw[i%4], e_sqr[i%4]);
         end
         tick();
      end
   endtask

   task automatic test_phase_offset();
      logic [PW-1:0] pv [4] = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000};
      int e_sin [4] = '{2050, 4095, 2046, 1};
      int e_saw [4] = '{0, 1024, 2048, 3072};
      apply_reset(32'h0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         pha_word = pv[i];
         tick();
         tick();
         tick();
         checks++;
         if (wave_sin !== OW'(e_sin[i]) || wave_saw !== OW'(e_saw[i])) begin
            failures++;
            $display("FAIL phase_offset[%0d] got sin=%0d saw=%0d want %0d %0d",
                     i, wave_sin, wave_saw, e_sin[i], e_saw[i]);
         end
      end
      // Frozen phase: outputs must hold.
      tick();
      checks++;
      if (wave_sin !== 12'd1 || wave_saw !== 12'd3072) begin
         failures++;
         $display("FAIL phase_hold got sin=%0d saw=%0d want 1 3072", wave_sin, wave_saw);
      end
   endtask

   task automatic test_duty();
      logic [OW-1:0] prev_saw;
      logic          prev_hi;
      int bad_delta = 0;
      int last_edge = -1;
      int last_rise = -1;
      int n_per = 0;
      int min_per = 1000, max_per = 0;
      int min_hi = 1000, max_hi = 0;
      int min_lo = 1000, max_lo = 0;
      int len;
      int d;
      apply_reset(32'h028F_5C29, 32'h0);
      tick();
      tick();
      prev_saw = wave_saw;
      prev_hi  = wave_sqr[0];
      for (int c = 1; c <= 450; c++) begin
         tick();
         d = int'((wave_saw - prev_saw) & 12'hFFF);
         if (d != 40 && d != 41) bad_delta++;
         if (wave_sqr[0] != prev_hi) begin
            if (last_edge >= 0) begin
               len = c - last_edge;
               if (!wave_sqr[0]) begin
                  if (len < min_hi) min_hi = len;
                  if (len > max_hi) max_hi = len;
               end else begin
                  if (len < min_lo) min_lo = len;
                  if (len > max_lo) max_lo = len;
               end
            end
            if (wave_sqr[0]) begin
               if (last_rise >= 0) begin
                  len = c - last_rise;
                  n_per++;
                  if (len < min_per) min_per = len;
                  if (len > max_per) max_per = len;
               end
               last_rise = c;
            end
            last_edge = c;
         end
         prev_saw = wave_saw;
         prev_hi  = wave_sqr[0];
      end
      checks++;
      if (bad_delta != 0) begin
         failures++;
         $display("FAIL duty_saw_step got %0d bad steps want 0 (step 40..41)", bad_delta);
      end
      checks++;
      if (n_per < 3 || min_per < 99 || max_per > 101) begin
         failures++;
         $display("FAIL duty_period got n=%0d min=%0d max=%0d want n>=3 in 99..101",
                  n_per, min_per, max_per);
      end
      checks++;
      if (min_hi < 49 || max_hi > 51 || min_lo < 49 || max_lo > 51) begin
         failures++;
         $display("FAIL duty_high_low got hi=%0d..%0d lo=%0d..%0d want 49..51",
                  min_hi, max_hi, min_lo, max_lo);
      end
   endtask

   task automatic test_sweep();
      logic [PW-1:0] fv [4] = '{32'h028F_5C29, 32'h0D49_FB83, 32'h1A93_F706, 32'h26DD_F485};
      int step_lo [4] = '{40, 212, 425, 621};
      int per_lo  [4] = '{99, 19, 9, 6};
      int per_hi  [4] = '{101, 20, 10, 7};
      logic [OW-1:0] prev_saw;
      logic          prev_hi;
      int bad_step = 0;
      int d;
      int len;
      int last_rise;
      int min_per, max_per, n_per;
      bit ok_old, ok_new;
      apply_reset(fv[0], 32'h0);
      tick();
      tick();
      prev_saw = wave_saw;
      prev_hi  = wave_sqr[0];
      for (int s = 0; s < 4; s++) begin
         fre_word  = fv[s];
         last_rise = -1;
         min_per   = 1000;
         max_per   = 0;
         n_per     = 0;
         for (int c = 0; c < 200; c++) begin
            tick();
            d = int'((wave_saw - prev_saw) & 12'hFFF);
            ok_new = (d == step_lo[s]) || (d == step_lo[s] + 1);
            ok_old = (s > 0) && ((d == step_lo[(s>0)?s-1:0]) || (d == step_lo[(s>0)?s-1:0] + 1));
            // The new word reaches the outputs a few samples after the switch.
            if (!(ok_new || (c < 4 && ok_old))) bad_step++;
            if (wave_sqr[0] && !prev_hi && c >= 4) begin
               if (last_rise >= 0) begin
                  len = c - last_rise;
                  n_per++;
                  if (len < min_per) min_per = len;
                  if (len > max_per) max_per = len;
               end
               last_rise = c;
            end
            prev_saw = wave_saw;
            prev_hi  = wave_sqr[0];
         end
         if (s > 0) begin
            checks++;
            if (n_per < 3 || min_per < per_lo[s] || max_per > per_hi[s]) begin
               failures++;
               $display("FAIL sweep_period[%0d] got n=%0d min=%0d max=%0d want %0d..%0d",
                        s, n_per, min_per, max_per, per_lo[s], per_hi[s]);
            end
         end
      end
      checks++;
      if (bad_step != 0) begin
         failures++;
         $display("FAIL sweep_continuity got %0d bad steps want 0", bad_step);
      end
   endtask

   task automatic test_midrun_reset();
      logic [4*OW-1:0] got;
      logic [4*OW-1:0] want;
      apply_reset(32'h1A93_F706, 32'h4000_0000);
      tick();
      tick();
      checks++;
      if (wave_sin !== 12'd4095 || wave_saw !== 12'd1024 ||
          wave_tri !== 12'd2048 || wave_sqr !== 12'd4095) begin
         failures++;
         $display("FAIL midrun_first got sin=%0d tri=%0d saw=%0d sqr=%0d want 4095 2048 1024 4095",
                  wave_sin, wave_tri, wave_saw, wave_sqr);
      end
      for (int i = 0; i < 20; i++) begin
         exp_q.push_back({wave_sin, wave_tri, wave_saw, wave_sqr});
         tick();
      end
      for (int i = 0; i < 37; i++) tick();
      #3;
      reset = 1'b0;
      #1;
      checks++;
      if ({wave_sin, wave_tri, wave_saw, wave_sqr} !== '0) begin
         failures++;
         $display("FAIL midrun_async got sin=%0d tri=%0d saw=%0d sqr=%0d want all 0",
                  wave_sin, wave_tri, wave_saw, wave_sqr);
      end
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 20; i++) begin
         got  = {wave_sin, wave_tri, wave_saw, wave_sqr};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL midrun_restart[%0d] got %h want %h", i, got, want);
         end
         tick();
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      reset    = 1'b0;
      fre_word = '0;
      pha_word = '0;
      test_reset();
      test_quarter_step();
      test_phase_offset();
      test_duty();
      test_sweep();
      test_midrun_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
